// File: rtl/instr_queue.sv
// instr_queue -- instruction FIFO with valid/ready enqueue and valid/yumi dequeue.
//
// Depth is CAP = 2^PTR_WIDTH_P entries. The read and write pointers carry one
// extra MSB so that "full" and "empty" can be told apart without a separate
// occupancy register. Occupancy is the pointer difference.
//
// Optional feature macro: IQ_BYPASS_EN
//   Undefined (default): valid_o/data_o come only from registered state and
//     storage; there is no combinational path from valid_i/data_i to them.
//   Defined: when the queue is empty, an incoming entry is presented directly
//     on valid_o/data_o in the same cycle. If the consumer takes it (yumi_i),
//     it is never written; otherwise it is written as a normal enqueue.
//
// ready_o is a pure function of registered pointers: a full queue does not
// accept a new entry even in the cycle its head is being consumed.

module instr_queue #(
  parameter int WIDTH_P        = 32,
  parameter int PTR_WIDTH_P    = 2,
  parameter int AFULL_THRESH_P = (1 << PTR_WIDTH_P) - 1
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   flush_i,
  input  logic [WIDTH_P-1:0]     data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic                   valid_o,
  output logic [WIDTH_P-1:0]     data_o,
  input  logic                   yumi_i,
  output logic [PTR_WIDTH_P:0]   count_o,
  output logic                   almost_full_o
);

  localparam int CAP = 1 << PTR_WIDTH_P;

  // Threshold expressed at the width of count_o so the compare is width-exact.
  localparam logic [PTR_WIDTH_P:0] AFULL_THRESH_L = (PTR_WIDTH_P+1)'(AFULL_THRESH_P);

  // Entry storage; written on enqueue, read combinationally at the head.
  logic [WIDTH_P-1:0] mem [CAP];

  // Pointers: low bits address storage, MSB is the wrap (lap) bit.
  logic [PTR_WIDTH_P:0]   wr_ptr_reg;
  logic [PTR_WIDTH_P:0]   wr_ptr_next;
  logic [PTR_WIDTH_P:0]   rd_ptr_reg;
  logic [PTR_WIDTH_P:0]   rd_ptr_next;
  logic [PTR_WIDTH_P-1:0] wr_addr;
  logic [PTR_WIDTH_P-1:0] rd_addr;

  logic empty;
  logic full;
  logic enq;
  logic deq;
  logic bypass_take;

  assign wr_addr = wr_ptr_reg[PTR_WIDTH_P-1:0];
  assign rd_addr = rd_ptr_reg[PTR_WIDTH_P-1:0];

  // Empty when pointers match exactly; full when only the lap bit differs.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PTR_WIDTH_P] != rd_ptr_reg[PTR_WIDTH_P]) &&
                 (wr_addr == rd_addr);

  // Status outputs derived only from registered pointers.
  assign ready_o       = !full;
  assign count_o       = wr_ptr_reg - rd_ptr_reg;
  assign almost_full_o = (count_o >= AFULL_THRESH_L);

`ifdef IQ_BYPASS_EN
  logic bypass_active;

  // An incoming entry is visible at the head only when nothing is stored.
  assign bypass_active = empty && valid_i && !flush_i;

  // Head presentation: stored head when non-empty, incoming entry otherwise.
  always_comb begin
    valid_o     = !empty || bypass_active;
    data_o      = mem[rd_addr];
    bypass_take = 1'b0;
    if (empty) begin
      data_o      = data_i;
      bypass_take = bypass_active && yumi_i;
    end
  end
`else
  // Head presentation: registered state and storage only.
  always_comb begin
    valid_o     = !empty;
    data_o      = mem[rd_addr];
    bypass_take = 1'b0;
  end
`endif

  // Transfer decode; a bypassed-and-consumed entry neither writes nor pops.
  always_comb begin
    enq = valid_i && ready_o && !flush_i && !bypass_take;
    deq = yumi_i && valid_o && !flush_i && !bypass_take;
  end

  // Pointer next-state; flush wins over any same-cycle transfer.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (enq) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (deq) rd_ptr_next = rd_ptr_reg + 1'b1;
    end
  end

  // Pointer registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Storage write; contents are not cleared by reset or flush.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem[wr_addr] <= data_i;
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue -- directed bench for instr_queue (default parameters).
// Expected head values are pushed into a scoreboard queue by the stimulus;
// a monitor pops and compares whenever the DUT hands over its head.
// Builds with or without IQ_BYPASS_EN.

module tb_instr_queue;

  localparam int W = 32;
  localparam int P = 2;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          flush_i;
  logic [W-1:0]  data_i;
  logic          valid_i;
  logic          ready_o;
  logic          valid_o;
  logic [W-1:0]  data_o;
  logic          yumi_i;
  logic [P:0]    count_o;
  logic          almost_full_o;

  int tests  = 0;
  int failed = 0;
  logic [W-1:0] sb [$];

  instr_queue #(.WIDTH_P(W), .PTR_WIDTH_P(P)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .flush_i(flush_i),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .valid_o(valid_o), .data_o(data_o), .yumi_i(yumi_i),
    .count_o(count_o), .almost_full_o(almost_full_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Advance one clock edge; inputs may change 1 time unit after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    valid_i = 1'b0; yumi_i = 1'b0; flush_i = 1'b0; data_i = '0;
  endtask

  task automatic enqueue(input logic [W-1:0] d);
    valid_i = 1'b1; yumi_i = 1'b0; data_i = d;
    sb.push_back(d);
    step();
    valid_i = 1'b0;
  endtask

  // Monitor: a handover happens when the head is valid and taken, not flushed.
  always @(negedge clk_i) begin
    if (reset_n_i && valid_o && yumi_i && !flush_i) begin
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no handover", data_o);
      end else begin
        check("pop_data", data_o, sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset_n_i = 1'b0;
    #3;
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_afull", 32'(almost_full_o), 32'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    step();

    // Fill to full, then drain in order.
    begin
      logic [W-1:0] vals [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
      for (int i = 0; i < 4; i++) begin
        enqueue(vals[i]);
        check("fill_count", 32'(count_o), 32'(i + 1));
        check("fill_afull", 32'(almost_full_o), (i + 1 >= 3) ? 32'd1 : 32'd0);
        check("fill_ready", 32'(ready_o), (i + 1 < 4) ? 32'd1 : 32'd0);
      end
      for (int i = 0; i < 4; i++) begin
        yumi_i = 1'b1;
        step();
        yumi_i = 1'b0;
        check("drain_count", 32'(count_o), 32'(3 - i));
      end
      check("drain_valid", 32'(valid_o), 32'd0);
    end

    // Full queue offered a new entry while the head is consumed: no write.
    for (int i = 0; i < 4; i++) enqueue(32'hA0 + 32'(i));
    valid_i = 1'b1; data_i = 32'h55; yumi_i = 1'b1;
    step();
    idle();
    check("full_drain_count", 32'(count_o), 32'd3);
    check("full_drain_ready", 32'(ready_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      yumi_i = 1'b1;
      step();
    end
    idle();
    check("full_drain_empty", 32'(count_o), 32'd0);

    // Steady state at count 2 across pointer wrap-around.
    enqueue(32'hB0);
    enqueue(32'hB1);
    for (int i = 0; i < 10; i++) begin
      valid_i = 1'b1; yumi_i = 1'b1; data_i = 32'hC0 + 32'(i);
      sb.push_back(data_i);
      step();
      check("stream_count", 32'(count_o), 32'd2);
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      yumi_i = 1'b1;
      step();
    end
    idle();
    check("stream_empty", 32'(count_o), 32'd0);

    // Flush at count 3 with a simultaneous enqueue and dequeue.
    for (int i = 0; i < 3; i++) enqueue(32'hD0 + 32'(i));
    sb.delete();
    flush_i = 1'b1; valid_i = 1'b1; data_i = 32'hEE; yumi_i = 1'b1;
    step();
    idle();
    check("flush_count", 32'(count_o), 32'd0);
    check("flush_valid", 32'(valid_o), 32'd0);
    step();
    check("flush_lost", 32'(valid_o), 32'd0);

    // Asynchronous reset between edges at count 2.
    enqueue(32'hE0);
    enqueue(32'hE1);
    check("pre_rst_count", 32'(count_o), 32'd2);
    #2;
    reset_n_i = 1'b0;
    #1;
    check("async_rst_valid", 32'(valid_o), 32'd0);
    check("async_rst_count", 32'(count_o), 32'd0);
    check("async_rst_ready", 32'(ready_o), 32'd1);
    sb.delete();
    @(negedge clk_i);
    reset_n_i = 1'b1;
    step();

    // Empty queue with an incoming entry and yumi asserted.
    valid_i = 1'b1; data_i = 32'hAB; yumi_i = 1'b1;
`ifdef IQ_BYPASS_EN
    sb.push_back(32'hAB);
    #1;
    check("byp_valid", 32'(valid_o), 32'd1);
    check("byp_data", data_o, 32'hAB);
    step();
    idle();
    check("byp_count", 32'(count_o), 32'd0);
`else
    #1;
    check("nobyp_valid", 32'(valid_o), 32'd0);
    step();
    idle();
    sb.push_back(32'hAB);
    check("nobyp_count", 32'(count_o), 32'd1);
    check("nobyp_valid_after", 32'(valid_o), 32'd1);
    check("nobyp_data", data_o, 32'hAB);
    yumi_i = 1'b1;
    step();
    idle();
    check("nobyp_empty", 32'(count_o), 32'd0);
`endif

    step();
    check("sb_leftover", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
